// File: rtl/pe_tile_sched.sv
// Row-tile scheduler for a single PE: sends the config, streams filter/ifmap/ipsum
// words from the GLB read port through one staging register, and writes opsums back.
module pe_tile_sched #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int CFG_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg,
  input  logic [4:0]        num_cols,
  input  logic [ADDR_W-1:0] filt_base,
  input  logic [ADDR_W-1:0] ifmap_base,
  input  logic [ADDR_W-1:0] ipsum_base,
  input  logic [ADDR_W-1:0] opsum_base,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              PE_en,
  output logic [CFG_W-1:0]  i_config,
  output logic [DATA_W-1:0] ifmap,
  output logic [DATA_W-1:0] filter,
  output logic [DATA_W-1:0] ipsum,
  output logic              ifmap_valid,
  output logic              filter_valid,
  output logic              ipsum_valid,
  input  logic              ifmap_ready,
  input  logic              filter_ready,
  input  logic              ipsum_ready,
  input  logic [DATA_W-1:0] opsum,
  input  logic              opsum_valid,
  output logic              opsum_ready
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CFG   = 3'd1;
  localparam logic [2:0] S_FILT  = 3'd2;
  localparam logic [2:0] S_IFMAP = 3'd3;
  localparam logic [2:0] S_IPSUM = 3'd4;
  localparam logic [2:0] S_OPSUM = 3'd5;
  localparam logic [2:0] S_SLIDE = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]        state_r;
  logic [CFG_W-1:0]  cfg_r;
  logic [2:0]        p_r;
  logic [4:0]        cols_r;
  logic [4:0]        col_r;
  logic [ADDR_W-1:0] filt_base_r;
  logic [ADDR_W-1:0] ifmap_base_r;
  logic [ADDR_W-1:0] ipsum_base_r;
  logic [ADDR_W-1:0] opsum_base_r;
  logic [3:0]        rd_cnt_r;
  logic [3:0]        hs_cnt_r;
  logic              pend_r;
  logic              buf_full_r;
  logic [DATA_W-1:0] buf_r;

  logic              load_s;
  logic [3:0]        n_words_s;
  logic              ready_s;
  logic              hs_s;
  logic              last_hs_s;
  logic              rd_en_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              op_hs_s;
  logic              op_last_s;
  logic              more_cols_s;
  logic [ADDR_W-1:0] col4_s;
  logic [ADDR_W-1:0] col1_s;
  logic [ADDR_W-1:0] rd_k_s;
  logic [ADDR_W-1:0] wr_k_s;

  assign col4_s = {{(ADDR_W-7){1'b0}}, col_r, 2'b00};
  assign col1_s = {{(ADDR_W-5){1'b0}}, col_r};
  assign rd_k_s = {{(ADDR_W-4){1'b0}}, rd_cnt_r};
  assign wr_k_s = {{(ADDR_W-4){1'b0}}, hs_cnt_r};

  // Phase word count, phase ready select and read address for the current load phase
  always_comb begin
    load_s    = 1'b0;
    n_words_s = 4'd0;
    ready_s   = 1'b0;
    rd_addr_s = {ADDR_W{1'b0}};
    case (state_r)
      S_FILT: begin
        load_s    = 1'b1;
        n_words_s = {1'b0, p_r} + {p_r, 1'b0};
        ready_s   = filter_ready;
        rd_addr_s = filt_base_r + rd_k_s;
      end
      S_IFMAP: begin
        load_s    = 1'b1;
        n_words_s = 4'd3;
        ready_s   = ifmap_ready;
        rd_addr_s = ifmap_base_r + rd_k_s;
      end
      S_SLIDE: begin
        load_s    = 1'b1;
        n_words_s = 4'd1;
        ready_s   = ifmap_ready;
        rd_addr_s = ifmap_base_r + {{(ADDR_W-2){1'b0}}, 2'b10} + col1_s;
      end
      S_IPSUM: begin
        load_s    = 1'b1;
        n_words_s = 4'd4;
        ready_s   = ipsum_ready;
        rd_addr_s = ipsum_base_r + col4_s + rd_k_s;
      end
      default: begin
        load_s    = 1'b0;
        n_words_s = 4'd0;
        ready_s   = 1'b0;
        rd_addr_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  // A new read may only start once the previous word has landed, so the single
  // staging register can never be overrun while the PE stalls.
  assign hs_s        = load_s && buf_full_r && ready_s;
  assign last_hs_s   = hs_s && (hs_cnt_r == (n_words_s - 4'd1));
  assign rd_en_s     = load_s && (rd_cnt_r < n_words_s) && !pend_r && (!buf_full_r || hs_s);
  assign op_hs_s     = (state_r == S_OPSUM) && opsum_valid;
  assign op_last_s   = op_hs_s && (hs_cnt_r == 4'd3);
  assign more_cols_s = ({1'b0, col_r} + 6'd1) < {1'b0, cols_r};

  // Tile sequencing and latching of the tile parameters on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      cfg_r        <= {CFG_W{1'b0}};
      p_r          <= 3'd0;
      cols_r       <= 5'd0;
      col_r        <= 5'd0;
      filt_base_r  <= {ADDR_W{1'b0}};
      ifmap_base_r <= {ADDR_W{1'b0}};
      ipsum_base_r <= {ADDR_W{1'b0}};
      opsum_base_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            cfg_r        <= cfg;
            p_r          <= {1'b0, cfg[8:7]} + 3'd1;
            cols_r       <= (num_cols == 5'd0) ? 5'd1 : num_cols;
            col_r        <= 5'd0;
            filt_base_r  <= filt_base;
            ifmap_base_r <= ifmap_base;
            ipsum_base_r <= ipsum_base;
            opsum_base_r <= opsum_base;
            state_r      <= S_CFG;
          end
        end
        S_CFG:   state_r <= S_FILT;
        S_FILT:  if (last_hs_s) state_r <= S_IFMAP;
        S_IFMAP: if (last_hs_s) state_r <= S_IPSUM;
        S_SLIDE: if (last_hs_s) state_r <= S_IPSUM;
        S_IPSUM: if (last_hs_s) state_r <= S_OPSUM;
        S_OPSUM: begin
          if (op_last_s) begin
            if (more_cols_s) begin
              col_r   <= col_r + 5'd1;
              state_r <= S_SLIDE;
            end else begin
              state_r <= S_DONE;
            end
          end
        end
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Per-phase read/handshake counters; hs_cnt_r doubles as the opsum word index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_r <= 4'd0;
      hs_cnt_r <= 4'd0;
    end else if (state_r == S_OPSUM) begin
      rd_cnt_r <= 4'd0;
      if (op_hs_s) hs_cnt_r <= op_last_s ? 4'd0 : hs_cnt_r + 4'd1;
    end else if (!load_s || last_hs_s) begin
      rd_cnt_r <= 4'd0;
      hs_cnt_r <= 4'd0;
    end else begin
      rd_cnt_r <= rd_cnt_r + {3'd0, rd_en_s};
      hs_cnt_r <= hs_cnt_r + {3'd0, hs_s};
    end
  end

  // Staging register: fills one cycle after a read, empties on a PE handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= 1'b0;
      buf_full_r <= 1'b0;
      buf_r      <= {DATA_W{1'b0}};
    end else begin
      pend_r <= rd_en_s;
      if (pend_r) begin
        buf_r      <= rd_data;
        buf_full_r <= 1'b1;
      end else if (hs_s) begin
        buf_full_r <= 1'b0;
      end
    end
  end

  assign busy         = (state_r != S_IDLE) && (state_r != S_DONE);
  assign done         = (state_r == S_DONE);
  assign PE_en        = (state_r == S_CFG);
  assign i_config     = cfg_r;
  assign rd_en        = rd_en_s;
  assign rd_addr      = rd_en_s ? rd_addr_s : {ADDR_W{1'b0}};
  assign filter       = buf_r;
  assign ifmap        = buf_r;
  assign ipsum        = buf_r;
  assign filter_valid = (state_r == S_FILT) && buf_full_r;
  assign ifmap_valid  = ((state_r == S_IFMAP) || (state_r == S_SLIDE)) && buf_full_r;
  assign ipsum_valid  = (state_r == S_IPSUM) && buf_full_r;
  assign opsum_ready  = (state_r == S_OPSUM);
  assign wr_en        = op_hs_s;
  assign wr_addr      = op_hs_s ? (opsum_base_r + col4_s + wr_k_s) : {ADDR_W{1'b0}};
  assign wr_data      = op_hs_s ? opsum : {DATA_W{1'b0}};

endmodule
